// File: rtl/hilo_muldiv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_ctrl_pkg
//   Shared types and constants for the HI/LO multiply/divide sequencer.
//   - word_t / i32    : 32-bit data words (unsigned / signed views)
//   - muldiv_op_t     : HI/LO operation encoding carried on issue_op
//   - md_state_t      : sequencer state encoding
//   - DIV_STEPS       : number of serial divide iterations
//   - neg_if()        : conditional two's-complement negation used by the
//                       divide sign fix-up
// -----------------------------------------------------------------------------
package hilo_muldiv_ctrl_pkg;

    typedef logic [31:0]        word_t;
    typedef logic signed [31:0] i32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_t;

    localparam int DIV_STEPS = 32;

    // Two's-complement negate v when c is set, pass it through otherwise.
    function automatic word_t neg_if(input word_t v, input logic c);
        word_t r;
        if (c) begin
            r = 32'd0 - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div_iter.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_ctrl_div_iter
//   One step of a serial restoring divider (purely combinational).
//   The partial remainder is shifted left, the next dividend bit enters at the
//   bottom, and the divisor is subtracted when it fits; the resulting quotient
//   bit is shifted into the bottom of the dividend/quotient register.
//
//   Ports:
//     rem_i  [32:0] partial remainder before the step
//     quo_i  [31:0] dividend bits not yet consumed / quotient bits produced
//     dsr_i  [31:0] divisor magnitude
//     rem_o  [32:0] partial remainder after the step
//     quo_o  [31:0] quo_i shifted left with the new quotient bit appended
// -----------------------------------------------------------------------------
module hilo_muldiv_ctrl_div_iter
    import hilo_muldiv_ctrl_pkg::*;
(
    input  logic [32:0] rem_i,
    input  word_t       quo_i,
    input  word_t       dsr_i,
    output logic [32:0] rem_o,
    output word_t       quo_o
);

    logic [32:0] shifted_s;
    logic [32:0] diff_s;
    logic        ge_s;

    // Shift-compare-subtract for one quotient bit.
    always_comb begin
        shifted_s = {rem_i[31:0], quo_i[31]};
        diff_s    = shifted_s - {1'b0, dsr_i};
        // rem_i[32] can only be set when the divisor is zero, where the
        // compare is always true anyway; folding it in keeps the bit live.
        ge_s      = rem_i[32] | (shifted_s >= {1'b0, dsr_i});
        if (ge_s) begin
            rem_o = diff_s;
        end else begin
            rem_o = shifted_s;
        end
        quo_o = {quo_i[30:0], ge_s};
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_ctrl
//   Sequencer for the HI/LO register pair. Accepts MULT/MULTU/DIV/DIVU/
//   MTHI/MTLO from execute, runs a fixed-latency multiply or a 32-step serial
//   restoring divide followed by one sign fix-up cycle, and owns hi/lo.
//
//   Parameters:
//     MUL_LAT      multiply latency in busy cycles (>= 1)
//
//   Ports:
//     clk          rising-edge clock
//     resetn       asynchronous active-low reset
//     issue_valid  execute presents a HI/LO op this cycle
//     issue_op     muldiv_op_t encoding of the op
//     src_a/src_b  forwarded rs/rt operands
//     flush        abandon the in-flight op and ignore this cycle's issue
//     rd_hilo      decode holds MFHI/MFLO this cycle
//     hi/lo        HI and LO registers
//     busy         an operation is in flight
//     done         one-cycle pulse after a MUL/DIV result lands in hi/lo
//     stall        busy & (rd_hilo | issue_valid), combinational
// -----------------------------------------------------------------------------
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2
)
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        issue_valid,
    input  logic [2:0]  issue_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        rd_hilo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_STEPS - 1);

    md_state_t   state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    word_t       hi_q, hi_d;
    word_t       lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    // op_a: multiplicand, or dividend magnitude shifting into the quotient
    // op_b: multiplier, or divisor magnitude
    word_t       op_a_q, op_a_d;
    word_t       op_b_q, op_b_d;
    logic [32:0] rem_q, rem_d;
    word_t       raw_a_q, raw_a_d;
    logic        signed_q, signed_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic        dz_q, dz_d;

    muldiv_op_t  op_s;
    logic [63:0] ext_a_s;
    logic [63:0] ext_b_s;
    logic [63:0] prod_s;
    logic [32:0] rem_nx_s;
    word_t       quo_nx_s;

    hilo_muldiv_ctrl_div_iter u_div_iter (
        .rem_i (rem_q),
        .quo_i (op_a_q),
        .dsr_i (op_b_q),
        .rem_o (rem_nx_s),
        .quo_o (quo_nx_s)
    );

    // Multiply datapath: the low 64 bits of a product of 64-bit sign- or
    // zero-extended operands give the signed or unsigned 32x32 result.
    always_comb begin
        ext_a_s = {{32{signed_q & op_a_q[31]}}, op_a_q};
        ext_b_s = {{32{signed_q & op_b_q[31]}}, op_b_q};
        prod_s  = ext_a_s * ext_b_s;
    end

    // Next-state and next-register computation for the sequencer.
    always_comb begin
        op_s     = muldiv_op_t'(issue_op);
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        rem_d    = rem_q;
        raw_a_d  = raw_a_q;
        signed_d = signed_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        dz_d     = dz_q;

        case (state_q)
            ST_IDLE: begin
                if (issue_valid && !flush) begin
                    case (op_s)
                        MD_MTHI: hi_d = src_a;
                        MD_MTLO: lo_d = src_a;
                        MD_MULT, MD_MULTU: begin
                            state_d  = ST_MUL;
                            busy_d   = 1'b1;
                            cnt_d    = MUL_LOAD;
                            op_a_d   = src_a;
                            op_b_d   = src_b;
                            signed_d = (op_s == MD_MULT);
                        end
                        MD_DIV, MD_DIVU: begin
                            state_d  = ST_DIV;
                            busy_d   = 1'b1;
                            cnt_d    = DIV_LOAD;
                            signed_d = (op_s == MD_DIV);
                            sa_d     = (op_s == MD_DIV) & src_a[31];
                            sb_d     = (op_s == MD_DIV) & src_b[31];
                            op_a_d   = neg_if(src_a, (op_s == MD_DIV) & src_a[31]);
                            op_b_d   = neg_if(src_b, (op_s == MD_DIV) & src_b[31]);
                            rem_d    = 33'd0;
                            raw_a_d  = src_a;
                            dz_d     = (src_b == 32'd0);
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_MUL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q == 6'd0) begin
                    hi_d    = prod_s[63:32];
                    lo_d    = prod_s[31:0];
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end

            ST_DIV: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    rem_d  = rem_nx_s;
                    op_a_d = quo_nx_s;
                    if (cnt_q == 6'd0) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
            end

            ST_FIX: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    // A zero divisor skips the sign step: the shift-subtract
                    // already yields all-ones, and hi returns the raw dividend.
                    if (dz_q) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = raw_a_q;
                    end else begin
                        lo_d = neg_if(op_a_q, sa_q ^ sb_q);
                        hi_d = neg_if(rem_q[31:0], sa_q);
                    end
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state, hi/lo and operand registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 6'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            op_a_q   <= 32'd0;
            op_b_q   <= 32'd0;
            rem_q    <= 33'd0;
            raw_a_q  <= 32'd0;
            signed_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            rem_q    <= rem_d;
            raw_a_q  <= raw_a_d;
            signed_q <= signed_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            dz_q     <= dz_d;
        end
    end

    // Output mapping; stall deliberately sees live decode/issue requests.
    always_comb begin
        hi    = hi_q;
        lo    = lo_q;
        busy  = busy_q;
        done  = done_q;
        stall = busy_q & (rd_hilo | issue_valid);
    end

endmodule
